// File: rtl/pulse_pattern_capture.sv
// Serial MSB-first deserialiser for the rotating pulse pattern stream.
// Presents each completed frame and asserts lock once a pattern repeats back-to-back.
module pulse_pattern_capture #(
    parameter int WIDTH      = 16,
    parameter int LOCK_COUNT = 3
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             din,
    output logic [WIDTH-1:0] Q_word,
    output logic             word_valid,
    output logic             locked,
    output logic             mismatch
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] ref_word;
    logic             ref_valid;
    logic [CW-1:0]    bit_cnt;
    logic [MW-1:0]    match_cnt;
    logic [WIDTH-1:0] next_word;

    assign next_word = {shreg[WIDTH-2:0], din};

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            ref_word   <= '0;
            ref_valid  <= 1'b0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            Q_word     <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            mismatch   <= 1'b0;

            // start (re)aligns and drops any partial frame, even on a completion edge
            if (start) begin
                state     <= SHIFT;
                bit_cnt   <= '0;
                ref_valid <= 1'b0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else if (state == SHIFT) begin
                shreg <= next_word;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    Q_word     <= next_word;
                    word_valid <= 1'b1;

                    if (!ref_valid) begin
                        ref_word  <= next_word;
                        ref_valid <= 1'b1;
                        match_cnt <= '0;
                    end else if (next_word == ref_word) begin
                        if (match_cnt < LOCK_MAX) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt + 1'b1 == LOCK_MAX)
                                locked <= 1'b1;
                        end
                    end else begin
                        mismatch  <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        ref_word  <= next_word;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
